pipeline_stage_reg: RTL and testbench
=====================================

PIPELINE_STAGE_REG -- requirements
Module: pipeline_stage_reg

Interface
REQ-001 SHALL have parameter WIDTH, default 32: payload width in bits.
REQ-002 SHALL have parameter RESET_VAL, default '0: payload value loaded by reset and flush, WIDTH bits.
REQ-003 SHALL have port CLK  input  1  sole clock; all state changes on the rising edge.
REQ-004 SHALL have port RST  input  1  synchronous, active-high reset.
REQ-005 SHALL have port en  input  1  global advance enable (memory-hit qualifier); low = freeze.
REQ-006 SHALL have port flush  input  1  discard all held entries (bubble insert).
REQ-007 SHALL have port in_valid  input  1  upstream payload present.
REQ-008 SHALL have port in_ready  output  1  stage can accept a payload this cycle.
REQ-009 SHALL have port in_data  input  WIDTH  upstream payload (decoded control and operands).
REQ-010 SHALL have port out_valid  output  1  head entry valid.
REQ-011 SHALL have port out_ready  input  1  downstream accepts the head this cycle.
REQ-012 SHALL have port out_data  output  WIDTH  head payload; RESET_VAL when out_valid is low.
REQ-013 SHALL have port count  output  2  number of occupied entries (0..2).

Function
REQ-014 SHALL push on a rising edge iff en && in_valid && in_ready, and pop iff en && out_valid && out_ready.
REQ-015 SHALL implement states EMPTY (count 0), HALF (count 1) and FULL (count 2).
- EMPTY: push -> HALF.
- HALF: push only -> FULL; pop only -> EMPTY; push+pop -> HALF with new data as head.
- FULL: pop -> HALF, second entry promoted to head.
- Otherwise hold.
REQ-016 SHALL drive in_ready = en && (state != FULL) from registered state only, with no combinational path from out_ready.
REQ-017 SHALL drive out_valid high iff state != EMPTY, independent of en.
REQ-018 SHALL preserve FIFO order: entries leave in acceptance order, with no loss or duplication.
REQ-019 SHALL present a payload pushed at edge N on out_data after edge N when the stage was EMPTY or popped at edge N (one-cycle latency).
REQ-020 SHALL, when en is low, hold all state, count and data, ignore flush, and perform no push or pop.
REQ-021 SHALL, when en && flush, go to EMPTY, set every entry to RESET_VAL and drop any simultaneous push or pop; flush has priority over push and pop.
REQ-022 SHALL keep entry slots not holding live data at RESET_VAL.

Reset
REQ-023 SHALL, when RST is high at a rising edge, enter EMPTY with count=0, out_valid=0, out_data=RESET_VAL and all entries RESET_VAL, regardless of en, flush or handshakes.
REQ-024 SHALL give RST priority over en and flush; mid-operation reset discards held payloads.
REQ-025 SHALL have in_ready equal to en in the cycle after reset.

Configuration
REQ-026 SHALL honour macro PIPELINE_SKID_EN.
- Defined: two-entry skid behaviour per REQ-015..REQ-016.
- Undefined: single entry, states EMPTY/HALF only, count never exceeds 1, and in_ready = en && (!out_valid || out_ready). This is a combinational out_ready-to-in_ready path that permits simultaneous pop and push.
- Reset, flush and en rules are identical in both builds.

Structure
REQ-027 SHALL take the typedef stage_state_t {EMPTY, HALF, FULL} and the constant STAGE_MAX_DEPTH=2 from shared package pipeline_stage_pkg.
REQ-028 SHALL build each slot from sub-module pipeline_stage_slot: a WIDTH register with load, clear-to-RESET_VAL and hold inputs, instantiated twice (once without PIPELINE_SKID_EN).
REQ-029 SHALL be usable as a drop-in IF/ID, ID/EX, EX/MEM or MEM/WB latch by packing each stage's control and data fields into in_data.

Verification (WIDTH=32, PIPELINE_SKID_EN defined unless stated)
REQ-030 SHALL cover reset: RST=1 with in_valid=1, in_data=32'hDEADBEEF -> next cycle count=0, out_valid=0, out_data=RESET_VAL.
REQ-031 SHALL cover fill: out_ready=0, push 32'h11 then 32'h22 -> count 1 then 2, in_ready=0 in FULL, out_data=32'h11; then out_ready=1 -> 32'h11 leaves, then 32'h22, count 2->1->0.
REQ-032 SHALL cover freeze: HALF holding 32'hA5, en=0 with in_valid=1, out_ready=1, flush=1 for 3 cycles -> count=1 and out_data=32'hA5 unchanged, in_ready=0.
REQ-033 SHALL cover flush: FULL, en=1, flush=1, in_valid=1, out_ready=1 -> next cycle count=0, out_valid=0, and no payload emitted or accepted.
REQ-034 SHALL cover streaming: HALF holding 32'h1, push 32'h2 with pop in the same cycle -> count stays 1, out_data=32'h2; stream 100 random payloads with random out_ready -> output sequence equals input sequence.
REQ-035 SHALL cover the no-skid build: EMPTY, push 32'h7, then out_ready=1 with in_valid=1, in_data=32'h8 -> same-cycle in_ready=1, and out_data becomes 32'h8 the next cycle.

Source files
------------

// File: rtl/pipeline_stage_pkg.sv
// ============================================================================
// Module      : pipeline_stage_pkg
// Description : Shared occupancy state encoding and depth constant for the
//               pipeline stage register and its slots.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pipeline_stage_pkg;

   // Encoding doubles as the occupancy count, so the state drives count directly.
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      HALF  = 2'd1,
      FULL  = 2'd2
   } stage_state_t;

   localparam int STAGE_MAX_DEPTH = 2;

endpackage : pipeline_stage_pkg

`default_nettype wire

// File: rtl/pipeline_stage_slot.sv
// ============================================================================
// Module      : pipeline_stage_slot
// Description : One payload register with hold, clear-to-RESET_VAL and load.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipeline_stage_slot #(
   parameter int               WIDTH     = 32,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             hold,
   input  logic             clear,
   input  logic             load,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] r_q;

   // hold outranks clear and load so a frozen pipeline ignores flushes too.
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_q <= RESET_VAL;
      end else if (!hold) begin
         if (clear) begin
            r_q <= RESET_VAL;
         end else if (load) begin
            r_q <= d;
         end
      end
   end

   assign q = r_q;

endmodule : pipeline_stage_slot

`default_nettype wire

// File: rtl/pipeline_stage_reg.sv
// ============================================================================
// Module      : pipeline_stage_reg
// Description : Valid/ready pipeline latch; two-entry skid buffer when
//               PIPELINE_SKID_EN is defined, single entry otherwise.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipeline_stage_reg
   import pipeline_stage_pkg::*;
#(
   parameter int               WIDTH     = 32,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             en,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [1:0]       count
);

   stage_state_t     r_state;
   stage_state_t     w_next;
   logic             w_push;
   logic             w_pop;
   logic             w_hold;
   logic             w_head_load;
   logic             w_head_clr;
   logic [WIDTH-1:0] w_head_d;
   logic [WIDTH-1:0] w_head_q;
`ifdef PIPELINE_SKID_EN
   logic             w_tail_load;
   logic             w_tail_clr;
   logic [WIDTH-1:0] w_tail_q;
`endif

   assign w_hold    = !en;
   assign out_valid = (r_state != EMPTY);
   assign out_data  = w_head_q;
   assign count     = r_state;
   assign w_push    = en && in_valid && in_ready;
   assign w_pop     = en && out_valid && out_ready;

`ifdef PIPELINE_SKID_EN
   assign in_ready = en && (r_state != FULL);
`else
   assign in_ready = en && (!out_valid || out_ready);
`endif

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state <= EMPTY;
      end else if (en) begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next      = r_state;
      w_head_load = 1'b0;
      w_head_clr  = 1'b0;
      w_head_d    = in_data;
`ifdef PIPELINE_SKID_EN
      w_tail_load = 1'b0;
      w_tail_clr  = 1'b0;
`endif
      if (flush) begin
         w_next     = EMPTY;
         w_head_clr = 1'b1;
`ifdef PIPELINE_SKID_EN
         w_tail_clr = 1'b1;
`endif
      end else begin
         case (r_state)
            EMPTY: begin
               if (w_push) begin
                  w_next      = HALF;
                  w_head_load = 1'b1;
               end
            end
            HALF: begin
               if (w_push && w_pop) begin
                  w_head_load = 1'b1;
               end else if (w_pop) begin
                  w_next     = EMPTY;
                  w_head_clr = 1'b1;
`ifdef PIPELINE_SKID_EN
               end else if (w_push) begin
                  w_next      = FULL;
                  w_tail_load = 1'b1;
`endif
               end
            end
`ifdef PIPELINE_SKID_EN
            // in_ready is low here, so only a pop can occur: promote the tail.
            FULL: begin
               if (w_pop) begin
                  w_next      = HALF;
                  w_head_load = 1'b1;
                  w_head_d    = w_tail_q;
                  w_tail_clr  = 1'b1;
               end
            end
`endif
            default: begin
               w_next = r_state;
            end
         endcase
      end
   end

   pipeline_stage_slot #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL)
   ) u_head_slot (
      .CLK   (CLK),
      .RST   (RST),
      .hold  (w_hold),
      .clear (w_head_clr),
      .load  (w_head_load),
      .d     (w_head_d),
      .q     (w_head_q)
   );

`ifdef PIPELINE_SKID_EN
   pipeline_stage_slot #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL)
   ) u_tail_slot (
      .CLK   (CLK),
      .RST   (RST),
      .hold  (w_hold),
      .clear (w_tail_clr),
      .load  (w_tail_load),
      .d     (in_data),
      .q     (w_tail_q)
   );
`endif

endmodule : pipeline_stage_reg

`default_nettype wire

// File: tb/tb_pipeline_stage_reg.sv
// ============================================================================
// Module      : tb_pipeline_stage_reg
// Description : Directed and streaming checks of pipeline_stage_reg
//               (skid or single-entry build, selected by PIPELINE_SKID_EN).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipeline_stage_reg;

   localparam int          c_WIDTH = 32;
   localparam logic [31:0] c_RST   = 32'h0;

   logic        CLK = 1'b0;
   logic        RST;
   logic        en;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic [1:0]  count;

   int n_cmp = 0;
   int n_err = 0;

   pipeline_stage_reg #(
      .WIDTH     (c_WIDTH),
      .RESET_VAL (c_RST)
   ) dut (
      .CLK       (CLK),
      .RST       (RST),
      .en        (en),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .count     (count)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   logic [31:0] sb_q[$];
   logic [31:0] payload;
   int          sent;
   int          recv;
   int          cyc;
   logic        exp_rdy;

   initial begin
      // Reset with a live push request that must be ignored
      RST = 1'b1; en = 1'b1; flush = 1'b0;
      in_valid = 1'b1; in_data = 32'hDEADBEEF; out_ready = 1'b0;
      #1;
      step();
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_data", out_data, c_RST);
      RST = 1'b0; in_valid = 1'b0;
      #1;
      chk("rst_in_ready", 32'(in_ready), 32'd1);

      // Fill with downstream stalled
      in_valid = 1'b1; in_data = 32'h11;
      step();
      chk("fill1_count", 32'(count), 32'd1);
      chk("fill1_data", out_data, 32'h11);
      in_data = 32'h22;
`ifdef PIPELINE_SKID_EN
      step();
      chk("fill2_count", 32'(count), 32'd2);
      chk("full_in_ready", 32'(in_ready), 32'd0);
      chk("fill2_data", out_data, 32'h11);
      in_valid = 1'b0; out_ready = 1'b1;
      #1;
      chk("drain_head", out_data, 32'h11);
      step();
      chk("drain1_count", 32'(count), 32'd1);
      chk("drain1_data", out_data, 32'h22);
      step();
      chk("drain2_count", 32'(count), 32'd0);
      chk("drain2_valid", 32'(out_valid), 32'd0);
      chk("drain2_data", out_data, c_RST);
`else
      #1;
      chk("half_stall_in_ready", 32'(in_ready), 32'd0);
      step();
      chk("stall_count", 32'(count), 32'd1);
      chk("stall_data", out_data, 32'h11);
      in_valid = 1'b0; out_ready = 1'b1;
      step();
      chk("drain_count", 32'(count), 32'd0);
      chk("drain_data", out_data, c_RST);
      // Pass-through: pop and push in the same cycle
      in_valid = 1'b1; in_data = 32'h7; out_ready = 1'b0;
      step();
      chk("ns_push7", out_data, 32'h7);
      in_data = 32'h8; out_ready = 1'b1;
      #1;
      chk("ns_same_cycle_ready", 32'(in_ready), 32'd1);
      step();
      chk("ns_push8", out_data, 32'h8);
      chk("ns_count", 32'(count), 32'd1);
      in_valid = 1'b0;
      step();
      chk("ns_drain", 32'(count), 32'd0);
`endif

      // Freeze: en low must ignore flush and all handshakes
      in_valid = 1'b1; in_data = 32'hA5; out_ready = 1'b0;
      step();
      en = 1'b0; flush = 1'b1; out_ready = 1'b1; in_data = 32'hFF;
      #1;
      chk("freeze_in_ready", 32'(in_ready), 32'd0);
      repeat (3) step();
      chk("freeze_count", 32'(count), 32'd1);
      chk("freeze_data", out_data, 32'hA5);
      chk("freeze_valid", 32'(out_valid), 32'd1);

      // Flush beats simultaneous push and pop
      en = 1'b1; flush = 1'b0; out_ready = 1'b0; in_data = 32'h33;
`ifdef PIPELINE_SKID_EN
      step();
      chk("pre_flush_full", 32'(count), 32'd2);
`endif
      flush = 1'b1; in_valid = 1'b1; in_data = 32'h55; out_ready = 1'b1;
      step();
      chk("flush_count", 32'(count), 32'd0);
      chk("flush_valid", 32'(out_valid), 32'd0);
      chk("flush_data", out_data, c_RST);
      flush = 1'b0; in_valid = 1'b0;
      step();
      chk("post_flush_count", 32'(count), 32'd0);

      // Push and pop together from HALF
      in_valid = 1'b1; in_data = 32'h1; out_ready = 1'b0;
      step();
      in_data = 32'h2; out_ready = 1'b1;
      step();
      chk("pp_count", 32'(count), 32'd1);
      chk("pp_data", out_data, 32'h2);
      in_valid = 1'b0;
      step();
      chk("pp_drain", 32'(count), 32'd0);

      // Random streaming against a queue scoreboard
      sent = 0; recv = 0; cyc = 0;
      payload = $urandom;
      while (recv < 100 && cyc < 3000) begin
         in_valid  = (sent < 100) && ($urandom_range(0, 3) != 0);
         in_data   = payload;
         out_ready = 1'($urandom_range(0, 1));
         #1;
`ifdef PIPELINE_SKID_EN
         exp_rdy = (sb_q.size() < 2);
`else
         exp_rdy = (sb_q.size() == 0) || out_ready;
`endif
         chk("st_in_ready", 32'(in_ready), 32'(exp_rdy));
         chk("st_count", 32'(count), 32'(sb_q.size()));
         if (out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
               chk("st_spurious", 32'(out_valid), 32'd0);
            end else begin
               chk("st_data", out_data, sb_q.pop_front());
            end
            recv++;
         end
         if (in_valid && in_ready) begin
            sb_q.push_back(payload);
            sent++;
            payload = $urandom;
         end
         step();
         cyc++;
      end
      chk("st_received", 32'(recv), 32'd100);
      in_valid = 1'b0;
      #1;
      chk("st_final_count", 32'(count), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule : tb_pipeline_stage_reg

`default_nettype wire
